csa_reduction_tree: RTL

- Pipelined partial-product generator and 3:2 carry-save reduction tree for a WIDTH x WIDTH multiplier; unsigned or signed.
- Produces a redundant sum/carry pair of 2*WIDTH bits. This pair drives in1/in2 of the downstream final carry-propagate adder stage.
- Runtime `pipes` selects how many reduction levels are registered, trading latency for clock rate in the same way as the final adder.

---
 rtl/csa_reduction_tree_if.sv | 25 ++
 rtl/csa_reduction_tree.sv | 115 +++++++++++
 2 files changed

// File: rtl/csa_reduction_tree_if.sv
// Operand/result bundle for the multiplier partial-product reduction tree.
// master drives operands and the pipeline select; slave returns the redundant pair.
interface csa_reduction_tree_if #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned PIPELINE_BITS = 3
) ();
  logic                     in_valid;
  logic [WIDTH-1:0]         a;
  logic [WIDTH-1:0]         b;
  logic                     is_signed;
  logic [PIPELINE_BITS-1:0] pipes;
  logic                     out_valid;
  logic [2*WIDTH-1:0]       sum;
  logic [2*WIDTH-1:0]       carry;

  modport master (
    output in_valid, a, b, is_signed, pipes,
    input  out_valid, sum, carry
  );

  modport slave (
    input  in_valid, a, b, is_signed, pipes,
    output out_valid, sum, carry
  );
endinterface

// File: rtl/csa_reduction_tree.sv
// Baugh-Wooley partial products reduced by 3:2 levels to a sum/carry pair.
// The last min(pipes, L) levels are registered; earlier levels are combinational.
module csa_reduction_tree #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned PIPELINE_BITS = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  csa_reduction_tree_if.slave bus
);
  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned NR = WIDTH + 1;

  // Row count after lvl levels of 3:2 compression (9, 6, 4, 3, 2 for WIDTH = 8).
  function automatic int unsigned rows_after(input int unsigned lvl);
    int unsigned n = NR;
    for (int unsigned k = 0; k < lvl; k++) n = 2 * (n / 3) + n % 3;
    return n;
  endfunction

  function automatic int unsigned num_levels(input int unsigned rows);
    int unsigned n = rows;
    int unsigned l = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + n % 3;
      l++;
    end
    return l;
  endfunction

  localparam int unsigned L = num_levels(NR);

  logic [PIPELINE_BITS-1:0] pipes_q;
  logic                     flush;
  logic [31:0]              p_eff;
  logic [NR*DW-1:0]         pp_rows;
  logic [WIDTH-1:0]         pp_row;

  assign flush = (bus.pipes != pipes_q);
  assign p_eff = (32'(bus.pipes) > 32'(L)) ? 32'(L) : 32'(bus.pipes);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipes_q <= '0;
    else        pipes_q <= bus.pipes;
  end

  // Sign-related bits are inverted in signed mode; correction adds 2^W + 2^(2W-1).
  always_comb begin
    pp_rows = '0;
    pp_row  = '0;
    for (int j = 0; j < int'(WIDTH); j++) begin
      pp_row = bus.a & {WIDTH{bus.b[j]}};
      if (j == int'(WIDTH) - 1) pp_row[WIDTH-2:0] = pp_row[WIDTH-2:0] ^ {(WIDTH-1){bus.is_signed}};
      else                      pp_row[WIDTH-1]   = pp_row[WIDTH-1] ^ bus.is_signed;
      pp_rows[j*DW +: DW] = DW'(pp_row) << j;
    end
    pp_rows[WIDTH*DW + WIDTH]  = bus.is_signed;
    pp_rows[WIDTH*DW + DW - 1] = bus.is_signed;
  end

  for (genvar i = 1; i <= int'(L); i++) begin : g_lvl
    localparam int unsigned NI = rows_after(i - 1);
    localparam int unsigned NO = rows_after(i);
    localparam int unsigned NG = NI / 3;

    logic [NI*DW-1:0] src;
    logic             src_v;
    logic [NO*DW-1:0] comb_rows;
    logic [NO*DW-1:0] q_rows;
    logic [NO*DW-1:0] rows;
    logic             q_v;
    logic             v;
    logic             reg_en;

    if (i == 1) begin : g_src
      assign src   = pp_rows;
      assign src_v = bus.in_valid;
    end else begin : g_src
      assign src   = g_lvl[i-1].rows;
      assign src_v = g_lvl[i-1].v;
    end

    for (genvar g = 0; g < int'(NG); g++) begin : g_csa
      logic [DW-1:0] x, y, z;
      assign x = src[(3*g)*DW +: DW];
      assign y = src[(3*g+1)*DW +: DW];
      assign z = src[(3*g+2)*DW +: DW];
      assign comb_rows[(2*g)*DW +: DW]   = x ^ y ^ z;
      assign comb_rows[(2*g+1)*DW +: DW] = ((x & y) | (x & z) | (y & z)) << 1;
    end

    // Rows left over from grouping by three pass straight through.
    if (NO > 2 * NG) begin : g_pass
      assign comb_rows[NO*DW-1 : 2*NG*DW] = src[NI*DW-1 : 3*NG*DW];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q_rows <= '0;
        q_v    <= 1'b0;
      end else begin
        q_v <= src_v & ~flush;
        if (src_v) q_rows <= comb_rows;
      end
    end

    assign reg_en = (32'(i) + p_eff) > 32'(L);
    assign rows   = reg_en ? q_rows : comb_rows;
    assign v      = reg_en ? q_v : src_v;
  end

  assign bus.sum       = g_lvl[L].rows[DW-1:0];
  assign bus.carry     = g_lvl[L].rows[2*DW-1:DW];
  assign bus.out_valid = g_lvl[L].v;
endmodule
